// File: rtl/wptr_level_ctrl.sv
// Write-side pointer and level controller for the dual-clock FIFO.
// Optional sticky overflow flag is built only when WPTR_OVF_EN is defined.
module wptr_level_ctrl #(
   parameter int PTR_WIDTH    = 4,
   parameter int AFULL_THRESH = 2
) (
   input  logic                 wclk,
   input  logic                 wrst_n,
   input  logic                 w_en,
   input  logic [PTR_WIDTH:0]   g_rptr_sync,
   input  logic                 ovf_clr,
   output logic [PTR_WIDTH:0]   b_wptr,
   output logic [PTR_WIDTH:0]   g_wptr,
   output logic [PTR_WIDTH-1:0] waddr,
   output logic                 full,
   output logic                 afull,
   output logic [PTR_WIDTH:0]   wfree,
   output logic                 wovf
);

   localparam int                 W       = PTR_WIDTH + 1;
   localparam logic [PTR_WIDTH:0] DEPTH_W = W'(1 << PTR_WIDTH);
   localparam logic [PTR_WIDTH:0] AFULL_W = W'(AFULL_THRESH);

   logic                 push;
   logic [PTR_WIDTH:0]   b_wptr_next;
   logic [PTR_WIDTH:0]   g_wptr_next;
   logic [PTR_WIDTH:0]   b_rptr_s;
   logic [PTR_WIDTH:0]   used_next;
   logic [PTR_WIDTH:0]   wfree_next;
   logic                 full_next;
   logic                 afull_next;

   assign push        = w_en & ~full;
   assign b_wptr_next = b_wptr + W'(push);
   assign g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next;

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      b_rptr_s = '0;
      for (int i = 0; i < W; i++) begin
         b_rptr_s[i] = ^(g_rptr_sync >> i);
      end
   end

   assign used_next  = b_wptr_next - b_rptr_s;
   assign wfree_next = DEPTH_W - used_next;
   assign full_next  = (g_wptr_next ==
                        {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]});
   assign afull_next = (wfree_next <= AFULL_W);

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         b_wptr <= '0;
         g_wptr <= '0;
         full   <= 1'b0;
         afull  <= 1'b0;
         wfree  <= DEPTH_W;
      end else begin
         b_wptr <= b_wptr_next;
         g_wptr <= g_wptr_next;
         full   <= full_next;
         afull  <= afull_next;
         wfree  <= wfree_next;
      end
   end

   assign waddr = b_wptr[PTR_WIDTH-1:0];

`ifdef WPTR_OVF_EN
   // A dropped write in the same cycle as a clear keeps the flag set.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wovf <= 1'b0;
      end else begin
         wovf <= (wovf & ~ovf_clr) | (w_en & full);
      end
   end
`else
   logic unused_ovf_clr;
   assign unused_ovf_clr = ovf_clr;
   assign wovf           = 1'b0;
`endif

endmodule
